div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 32 +++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU package: divider opcodes, FSM states and operand helpers.
package div_unit_pkg;

   localparam int unsigned DIV_DATA_W = 32;
   localparam int unsigned DIV_ITERS  = 32;

   // Opcode bit 0 selects unsigned, bit 1 selects remainder.
   typedef enum logic [1:0] {
      DIV_W  = 2'b00,
      DIV_WU = 2'b01,
      MOD_W  = 2'b10,
      MOD_WU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   // True for the two signed opcodes.
   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV_W) || (op == MOD_W);
   endfunction

   // Two's-complement magnitude; unsigned operands pass through untouched.
   function automatic logic [DIV_DATA_W-1:0] magnitude(input logic [DIV_DATA_W-1:0] x,
                                                       input logic is_signed);
      return (is_signed && x[DIV_DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit divider: radix-2 restoring, one quotient bit per cycle,
// result presented with a valid/ready handshake and cancellable by flush.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic [1:0]       div_op,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   output logic             div_out_valid,
   input  logic             div_out_ready,
   output logic [WIDTH-1:0] div_result
);

   localparam logic [5:0] LAST_CNT = 6'(DIV_ITERS);

   div_state_e       r_state;
   div_state_e       w_next;
   logic [5:0]       r_cnt;
   div_op_e          r_op;
   logic [WIDTH-1:0] r_src1;
   logic [WIDTH-1:0] r_dsor;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
   logic [WIDTH-1:0] r_result;

   div_op_e          w_op;
   logic             w_signed;
   logic             w_accept;
   logic             w_iter;
   logic             w_finish;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_final;

   assign w_op     = div_op_e'(div_op);
   assign w_signed = op_is_signed(w_op);
   assign w_accept = (r_state == IDLE) && div_valid && !flush;
   assign w_iter   = (r_state == CALC) && (r_cnt != LAST_CNT);
   assign w_finish = (r_state == CALC) && (r_cnt == LAST_CNT) && !flush;

   // Restoring step: shift in next dividend bit, keep the difference if non-negative.
   always_comb begin
      w_shift   = {r_rem, r_quo[WIDTH-1]};
      w_diff    = w_shift - {1'b0, r_dsor};
      w_qbit    = ~w_diff[WIDTH];
      w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   end

   // Sign fixup and divide-by-zero substitution on the finished magnitudes.
   always_comb begin
      w_final = '0;
      unique case (r_op)
         DIV_W, DIV_WU: w_final = r_dz ? '1     : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
         MOD_W, MOD_WU: w_final = r_dz ? r_src1 : (r_neg_r ? (~r_rem + 1'b1) : r_rem);
         default:       w_final = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Next state and handshake outputs; flush beats any accept or consume.
   always_comb begin
      w_next        = r_state;
      div_ready     = 1'b0;
      div_out_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            div_ready = 1'b1;
            if (w_accept) w_next = CALC;
         end
         CALC: begin
            if (flush)                  w_next = IDLE;
            else if (r_cnt == LAST_CNT) w_next = DONE;
         end
         DONE: begin
            div_out_valid = 1'b1;
            if (flush || div_out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand capture on accept, then one restoring iteration per CALC cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= '0;
         r_op    <= DIV_W;
         r_src1  <= '0;
         r_dsor  <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_op    <= w_op;
         r_src1  <= div_src1;
         r_dsor  <= magnitude(div_src2, w_signed);
         r_quo   <= magnitude(div_src1, w_signed);
         r_rem   <= '0;
         r_neg_q <= w_signed && (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
         r_neg_r <= w_signed && div_src1[WIDTH-1];
         r_dz    <= (div_src2 == '0);
      end else if (flush) begin
         r_cnt   <= '0;
      end else if (w_iter) begin
         r_cnt   <= r_cnt + 6'd1;
         r_rem   <= w_rem_nxt;
         r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
      end
   end

   // Result register: loaded on entry to DONE, zero whenever no result is offered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                  r_result <= '0;
      else if (flush)                               r_result <= '0;
      else if (w_finish)                            r_result <= w_final;
      else if (r_state == DONE && div_out_ready)    r_result <= '0;
   end

   assign div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model and per-cycle compare.
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        div_valid;
   logic        div_ready;
   logic [1:0]  div_op;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_out_valid;
   logic        div_out_ready;
   logic [31:0] div_result;

   int n_cmp = 0;
   int n_bad = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .div_valid    (div_valid),
      .div_ready    (div_ready),
      .div_op       (div_op),
      .div_src1     (div_src1),
      .div_src2     (div_src2),
      .div_out_valid(div_out_valid),
      .div_out_ready(div_out_ready),
      .div_result   (div_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: op bit0 = unsigned, bit1 = remainder.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end
      q = sa / sb;
      r = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   // Reference timeline: 0 idle, 1 computing, 2 result offered.
   int          m_mode;
   int          m_t;
   logic [31:0] m_res;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_mode <= 0;
         m_t    <= 0;
         m_res  <= '0;
      end else begin
         case (m_mode)
            0: if (div_valid && !flush) begin
                  m_mode <= 1;
                  m_t    <= 0;
                  m_res  <= ref_div(div_op, div_src1, div_src2);
               end
            1: if (flush) m_mode <= 0;
               else begin
                  m_t <= m_t + 1;
                  if (m_t == 32) m_mode <= 2;
               end
            2: if (flush || div_out_ready) m_mode <= 0;
            default: m_mode <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("cyc_ready", {31'd0, div_ready},     {31'd0, m_mode == 0});
      chk("cyc_valid", {31'd0, div_out_valid}, {31'd0, m_mode == 2});
      chk("cyc_result", div_result, (m_mode == 2) ? m_res : 32'd0);
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!div_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", {31'd0, div_ready}, 32'd1);
      div_op    = op;
      div_src1  = a;
      div_src2  = b;
      div_valid = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!div_out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 33);
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
      logic [31:0] first;
      issue(op, a, b);
      wait_done();
      chk(name, div_result, exp);
      first = div_result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_result", div_result, first);
         chk("hold_valid", {31'd0, div_out_valid}, 32'd1);
         chk("hold_ready", {31'd0, div_ready}, 32'd0);
      end
      div_out_ready = 1'b1;
      #1;
      chk("consume_ready", {31'd0, div_ready}, 32'd0);
      @(posedge clk); #1;
      div_out_ready = 1'b0;
      chk("after_ready", {31'd0, div_ready}, 32'd1);
      chk("after_valid", {31'd0, div_out_valid}, 32'd0);
   endtask

   task automatic expect_no_result(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         chk("no_result", {31'd0, div_out_valid}, 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn        = 1'b0;
      flush         = 1'b0;
      div_valid     = 1'b0;
      div_op        = 2'b00;
      div_src1      = '0;
      div_src2      = '0;
      div_out_ready = 1'b0;

      // Hand-computed pins on the reference model.
      chk("model_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
      chk("model_modw", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("model_ovf",  ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("model_dz",   ref_div(2'b11, 32'd5, 32'd0), 32'd5);

      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("rst_ready",  {31'd0, div_ready}, 32'd1);
      chk("rst_valid",  {31'd0, div_out_valid}, 32'd0);
      chk("rst_result", div_result, 32'd0);

      run_op("divu_100_7",  2'b01, 32'd100,         32'd7,           32'd14,          0);
      run_op("modu_100_7",  2'b11, 32'd100,         32'd7,           32'd2,           0);
      run_op("divw_m7_2",   2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   0);
      run_op("modw_m7_2",   2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   0);
      run_op("divw_ovf",    2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   0);
      run_op("modw_ovf",    2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           0);
      run_op("divw_dz",     2'b00, 32'd5,           32'd0,           32'hFFFF_FFFF,   0);
      run_op("divu_dz",     2'b01, 32'd5,           32'd0,           32'hFFFF_FFFF,   0);
      run_op("modw_dz",     2'b10, 32'd5,           32'd0,           32'd5,           0);
      run_op("modu_dz",     2'b11, 32'd5,           32'd0,           32'd5,           0);
      run_op("divw_max_m2", 2'b00, 32'h7FFF_FFFF,   32'hFFFF_FFFE,   32'hC000_0001,   0);
      run_op("modw_max_m2", 2'b10, 32'h7FFF_FFFF,   32'hFFFF_FFFE,   32'd1,           0);
      run_op("divu_big",    2'b01, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   0);
      run_op("divu_hold",   2'b01, 32'd1000,        32'd33,          32'd30,          5);

      // Flush at cycle 10 of the computation.
      issue(2'b00, 32'd12345, 32'd67);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", {31'd0, div_ready}, 32'd1);
      expect_no_result(40);

      // Flush beats a simultaneous request.
      div_op    = 2'b01;
      div_src1  = 32'd9;
      div_src2  = 32'd3;
      div_valid = 1'b1;
      flush     = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      flush     = 1'b0;
      chk("flush_vs_valid", {31'd0, div_ready}, 32'd1);
      expect_no_result(40);

      // Flush beats a simultaneous consume in DONE.
      issue(2'b01, 32'd77, 32'd7);
      wait_done();
      chk("pre_flush_res", div_result, 32'd11);
      flush         = 1'b1;
      div_out_ready = 1'b1;
      @(posedge clk); #1;
      flush         = 1'b0;
      div_out_ready = 1'b0;
      chk("flush_done_valid",  {31'd0, div_out_valid}, 32'd0);
      chk("flush_done_result", div_result, 32'd0);
      chk("flush_done_ready",  {31'd0, div_ready}, 32'd1);

      // Reset mid-operation abandons it.
      issue(2'b01, 32'd500, 32'd3);
      repeat (5) begin @(posedge clk); #1; end
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst_ready",  {31'd0, div_ready}, 32'd1);
      chk("midrst_valid",  {31'd0, div_out_valid}, 32'd0);
      chk("midrst_result", div_result, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      expect_no_result(40);

      run_op("post_rst_divu", 2'b01, 32'd500, 32'd3, 32'd166, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
